dma_spi: RTL and testbench

- SPI slave receiver for one 51-byte (408-bit) parameter frame from the MCU (MCU side drives it via DMA).
- Shifting runs in the SCLK domain. Once the frame completes, it is transferred to the clk domain and split into timing/frequency/pulse parameter registers for the synthesizer/sequencer.
- SPI_WR strobes each time new parameters become valid.

---
 rtl/dma_spi_pkg.sv | 41 ++++
 rtl/dma_spi_shifter.sv | 21 ++
 rtl/dma_spi.sv | 94 +++++++++
 tb/tb_dma_spi.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_spi_pkg.sv
// dma_spi_pkg: frame layout shared by the SPI parameter receiver.
// Fields are listed first-received to last-received, MSB first.
package dma_spi_pkg;
   localparam int FRAME_BITS = 408;
   localparam int CNT_W = 9;
   localparam int CNT_MAX = 409;
   localparam int TIME_W = 64;
   localparam int FREQ_W = 48;
   localparam int FREQ_STEP_W = 48;
   localparam int FREQ_RATE_W = 32;
   localparam int TIME_START_W = 64;
   localparam int N_IMP_W = 16;
   localparam int TYPE_IMP_W = 8;
   localparam int INTERVAL_W = 32;
   localparam int TBLANK_W = 32;
   localparam int TIME_MSB = 407;
   localparam int FREQ_MSB = 343;
   localparam int FREQ_STEP_MSB = 295;
   localparam int FREQ_RATE_MSB = 247;
   localparam int TIME_START_MSB = 215;
   localparam int N_IMP_MSB = 151;
   localparam int TYPE_IMP_MSB = 135;
   localparam int TI_MSB = 127;
   localparam int TP_MSB = 95;
   localparam int TBLANK1_MSB = 63;
   localparam int TBLANK2_MSB = 31;

   typedef struct packed {
      logic [TIME_W-1:0]       sys_time;
      logic [FREQ_W-1:0]       freq;
      logic [FREQ_STEP_W-1:0]  freq_step;
      logic [FREQ_RATE_W-1:0]  freq_rate;
      logic [TIME_START_W-1:0] time_start;
      logic [N_IMP_W-1:0]      n_impulse;
      logic [TYPE_IMP_W-1:0]   type_impulse;
      logic [INTERVAL_W-1:0]   interval_ti;
      logic [INTERVAL_W-1:0]   interval_tp;
      logic [TBLANK_W-1:0]     tblank1;
      logic [TBLANK_W-1:0]     tblank2;
   } dma_spi_frame_t;
endpackage

// File: rtl/dma_spi_shifter.sv
// dma_spi_shifter: SCLK-domain frame shift register and saturating bit counter.
// CS high asynchronously clears the counter; the shift register keeps its contents.
module dma_spi_shifter
   import dma_spi_pkg::*;
(
   input  logic                  sclk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  mosi,
   output logic [FRAME_BITS-1:0] shift,
   output logic [CNT_W-1:0]      cnt
);
   always_ff @(posedge sclk or negedge rst_n)
      if (!rst_n) shift <= '0;
      else if (!cs) shift <= {shift[FRAME_BITS-2:0], mosi};

   always_ff @(posedge sclk or negedge rst_n or posedge cs)
      if (!rst_n) cnt <= '0;
      else if (cs) cnt <= '0;
      else if (cnt != CNT_W'(CNT_MAX)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/dma_spi.sv
// dma_spi: SPI slave that receives a 408-bit parameter frame and latches it into clk-domain registers.
// Define DMA_SPI_LEN_CHECK_EN to drop frames that were not exactly FRAME_BITS bits long.
module dma_spi
   import dma_spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic        MOSI,
   input  logic        CS,
   input  logic        SCLK,
   output logic [63:0] TIME,
   output logic        SYS_TIME_UPDATE,
   output logic [47:0] FREQ,
   output logic [47:0] FREQ_STEP,
   output logic [31:0] FREQ_RATE,
   output logic [63:0] TIME_START,
   output logic [15:0] N_impulse,
   output logic [7:0]  TYPE_impulse,
   output logic [31:0] Interval_Ti,
   output logic [31:0] Interval_Tp,
   output logic [31:0] Tblank1,
   output logic [31:0] Tblank2,
   output logic        SPI_WR
);
`ifdef DMA_SPI_LEN_CHECK_EN
   localparam bit LEN_CHECK = 1'b1;
`else
   localparam bit LEN_CHECK = 1'b0;
`endif

   logic [FRAME_BITS-1:0]  shift;
   logic [CNT_W-1:0]       cnt, frame_cnt;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic                   cs_d, pending, rise, load;
   dma_spi_frame_t         frame;

   dma_spi_shifter u_shifter (
      .sclk (SCLK),
      .rst_n(rst_n),
      .cs   (CS),
      .mosi (MOSI),
      .shift(shift),
      .cnt  (cnt)
   );

   // shift and cnt are stable while CS is high (SCLK idle), so clk samples them directly
   assign frame = dma_spi_frame_t'(shift);
   assign rise  = cs_sync[SYNC_STAGES-1] & ~cs_d;
   assign load  = pending & clk_en & (!LEN_CHECK || frame_cnt == CNT_W'(FRAME_BITS));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cs_sync         <= '0;
         cs_d            <= 1'b0;
         pending         <= 1'b0;
         frame_cnt       <= '0;
         SPI_WR          <= 1'b0;
         SYS_TIME_UPDATE <= 1'b0;
         TIME            <= '0;
         FREQ            <= '0;
         FREQ_STEP       <= '0;
         FREQ_RATE       <= '0;
         TIME_START      <= '0;
         N_impulse       <= '0;
         TYPE_impulse    <= '0;
         Interval_Ti     <= '0;
         Interval_Tp     <= '0;
         Tblank1         <= '0;
         Tblank2         <= '0;
      end else begin
         cs_sync         <= SYNC_STAGES'({cs_sync, CS});
         cs_d            <= cs_sync[SYNC_STAGES-1];
         pending         <= rise | (pending & ~clk_en);
         if (rise) frame_cnt <= cnt;
         SPI_WR          <= load;
         SYS_TIME_UPDATE <= load & shift[TIME_MSB];
         if (load) begin
            TIME         <= frame.sys_time;
            FREQ         <= frame.freq;
            FREQ_STEP    <= frame.freq_step;
            FREQ_RATE    <= frame.freq_rate;
            TIME_START   <= frame.time_start;
            N_impulse    <= frame.n_impulse;
            TYPE_impulse <= frame.type_impulse;
            Interval_Ti  <= frame.interval_ti;
            Interval_Tp  <= frame.interval_tp;
            Tblank1      <= frame.tblank1;
            Tblank2      <= frame.tblank2;
         end
      end
endmodule

// File: tb/tb_dma_spi.sv
// tb_dma_spi: randomized frames against a bit-level model of the last 408 received bits.
// Build with DMA_SPI_LEN_CHECK_EN defined to expect short frames to be dropped.
`timescale 1ns/1ps
module tb_dma_spi;
`ifdef DMA_SPI_LEN_CHECK_EN
   localparam bit LEN_CHK = 1'b1;
`else
   localparam bit LEN_CHK = 1'b0;
`endif

   logic clk = 0, rst_n = 0, clk_en = 1, MOSI = 0, CS = 1, SCLK = 0;
   logic [63:0] TIME, TIME_START;
   logic [47:0] FREQ, FREQ_STEP;
   logic [31:0] FREQ_RATE, Interval_Ti, Interval_Tp, Tblank1, Tblank2;
   logic [15:0] N_impulse;
   logic [7:0]  TYPE_impulse;
   logic        SYS_TIME_UPDATE, SPI_WR;

   dma_spi dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .MOSI(MOSI), .CS(CS), .SCLK(SCLK),
      .TIME(TIME), .SYS_TIME_UPDATE(SYS_TIME_UPDATE), .FREQ(FREQ), .FREQ_STEP(FREQ_STEP),
      .FREQ_RATE(FREQ_RATE), .TIME_START(TIME_START), .N_impulse(N_impulse),
      .TYPE_impulse(TYPE_impulse), .Interval_Ti(Interval_Ti), .Interval_Tp(Interval_Tp),
      .Tblank1(Tblank1), .Tblank2(Tblank2), .SPI_WR(SPI_WR)
   );

   always #10 clk = ~clk;

   int checks = 0, errors = 0;
   int ncyc = 0, wr_cnt = 0, stu_cnt = 0, first_wr = -1, rise_cyc = 0, sent = 0;
   logic [407:0] model_sr = '0, exp_out = '0;

   always @(negedge clk) begin
      ncyc++;
      if (SPI_WR === 1'b1) begin
         wr_cnt++;
         if (first_wr < 0) first_wr = ncyc;
      end
      if (SYS_TIME_UPDATE === 1'b1) stu_cnt++;
   end

   function automatic logic [407:0] outs();
      return {TIME, FREQ, FREQ_STEP, FREQ_RATE, TIME_START, N_impulse, TYPE_impulse,
              Interval_Ti, Interval_Tp, Tblank1, Tblank2};
   endfunction

   function automatic logic [407:0] rand_frame();
      logic [407:0] r = '0;
      for (int i = 0; i < 13; i++) r = (r << 32) | 408'($urandom);
      return r;
   endfunction

   task automatic clear_mon();
      wr_cnt = 0; stu_cnt = 0; first_wr = -1;
   endtask

   task automatic send(input logic [407:0] d, input int n);
      clear_mon();
      CS = 0;
      #30;
      for (int i = n - 1; i >= 0; i--) begin
         MOSI = d[i];
         model_sr = {model_sr[406:0], d[i]};
         #25 SCLK = 1;
         #25 SCLK = 0;
      end
      sent = n;
      #20;
      @(posedge clk);
      #1 CS = 1;
      rise_cyc = ncyc;
   endtask

   task automatic expect_update(input string name, input bit fire, input bit chk_lat);
      int lat;
      repeat (12) @(negedge clk);
      checks++;
      if (wr_cnt !== (fire ? 1 : 0)) begin
         errors++;
         $display("FAIL %s spi_wr_pulses: got %0d want %0d", name, wr_cnt, fire ? 1 : 0);
      end
      if (fire) exp_out = model_sr;
      checks++;
      if (stu_cnt !== ((fire && model_sr[407]) ? 1 : 0)) begin
         errors++;
         $display("FAIL %s sys_time_pulses: got %0d want %0d", name, stu_cnt, (fire && model_sr[407]) ? 1 : 0);
      end
      if (fire && chk_lat) begin
         lat = first_wr - rise_cyc;
         checks++;
         if (first_wr < 0 || lat < 4 || lat > 5) begin
            errors++;
            $display("FAIL %s latency: got %0d want 4..5 negedges", name, lat);
         end
      end
      checks++;
      if (outs() !== exp_out) begin
         errors++;
         $display("FAIL %s outputs: got %h want %h", name, outs(), exp_out);
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      #35;
      checks++;
      if (outs() !== '0) begin
         errors++;
         $display("FAIL reset outputs: got %h want 0", outs());
      end
      checks++;
      if (SPI_WR !== 1'b0 || SYS_TIME_UPDATE !== 1'b0) begin
         errors++;
         $display("FAIL reset pulses: got %b%b want 00", SPI_WR, SYS_TIME_UPDATE);
      end
      rst_n = 1;
      repeat (10) @(negedge clk);
      clear_mon();
   endtask

   task automatic test_nominal();
      send({64'h8000000000000001, 48'd1, 48'd2, 32'd3, 64'd4, 16'd1, 8'd0,
            32'd5, 32'd6, 32'd7, 32'd8}, 408);
      expect_update("nominal", 1'b1, 1'b1);
      checks++;
      if (TIME !== 64'h8000000000000001 || Tblank2 !== 32'd8 || N_impulse !== 16'd1) begin
         errors++;
         $display("FAIL nominal fields: got %h %h %h want 8000000000000001 8 1", TIME, Tblank2, N_impulse);
      end
   endtask

   task automatic test_no_sys_time();
      send({64'h1, 48'd1, 48'd2, 32'd3, 64'd4, 16'd1, 8'd0,
            32'd5, 32'd6, 32'd7, 32'd8}, 408);
      expect_update("no_sys_time", 1'b1, 1'b1);
      checks++;
      if (TIME !== 64'h1) begin
         errors++;
         $display("FAIL no_sys_time time: got %h want 1", TIME);
      end
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 3; k++) begin
         send(rand_frame(), 408);
         expect_update($sformatf("back_to_back%0d", k), 1'b1, 1'b1);
      end
   endtask

   task automatic test_clk_en();
      clk_en = 0;
      send(rand_frame(), 408);
      send(rand_frame(), 408);
      repeat (20) @(negedge clk);
      checks++;
      if (wr_cnt !== 0 || stu_cnt !== 0) begin
         errors++;
         $display("FAIL clk_en_hold pulses: got %0d/%0d want 0/0", wr_cnt, stu_cnt);
      end
      checks++;
      if (outs() !== exp_out) begin
         errors++;
         $display("FAIL clk_en_hold outputs: got %h want %h", outs(), exp_out);
      end
      clk_en = 1;
      expect_update("clk_en_merge", 1'b1, 1'b0);
   endtask

   task automatic test_short();
      send(rand_frame(), 400);
      expect_update("short", !LEN_CHK, 1'b1);
      send(rand_frame(), 408);
      expect_update("after_short", 1'b1, 1'b1);
   endtask

   task automatic test_mid_reset();
      logic [407:0] d = rand_frame();
      clear_mon();
      CS = 0;
      #30;
      for (int i = 0; i < 150; i++) begin
         MOSI = d[i];
         #25 SCLK = 1;
         #25 SCLK = 0;
      end
      rst_n = 0;
      model_sr = '0;
      exp_out = '0;
      #15;
      checks++;
      if (outs() !== '0) begin
         errors++;
         $display("FAIL mid_reset outputs: got %h want 0", outs());
      end
      #15 rst_n = 1;
      #20;
      @(posedge clk);
      #1 CS = 1;
      rise_cyc = ncyc;
      expect_update("mid_reset_abort", !LEN_CHK, 1'b1);
      send(rand_frame(), 408);
      expect_update("mid_reset_full", 1'b1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_no_sys_time();
      test_back_to_back();
      test_clk_en();
      test_short();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
